// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 instruction-fetch path.
package z16_pkg;

  localparam int unsigned Z16_WORD_W = 16;
  localparam logic [Z16_WORD_W-1:0] Z16_PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    StRun,
    StHalt,
    StFault
  } fetch_state_e;

  typedef struct packed {
    logic [Z16_WORD_W-1:0] instr;
    logic [Z16_WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/z16_fetch_queue.sv
// Synchronous FIFO of fetched instructions; flush empties it, push into a full
// queue is accepted when a pop happens on the same edge.
module z16_fetch_queue
  import z16_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q < CntW'(Depth)) | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (do_pop) rd_q <= rd_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    head_o = '0;
    if (cnt_q != '0) head_o = mem_q[rd_q];
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/z16_instr_fetch_ctrl.sv
// Z16 fetch controller: owns the PC, reads a combinational instruction memory
// and queues fetched words for decode; handles redirect, halt and range faults.
module z16_instr_fetch_ctrl
  import z16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned MEM_WORDS   = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fault
);

  localparam int unsigned CntW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [15:0] MemWordsW = 16'(MEM_WORDS);

  fetch_state_e    state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic            push, flush, pop, can_push, in_range;
  fetch_entry_t    head, entry;
  logic [CntW-1:0] q_count;

  assign o_instr_valid = (q_count != '0);
  assign pop           = o_instr_valid & i_instr_ready;
  assign can_push      = (q_count < CntW'(QUEUE_DEPTH)) | pop;
  assign in_range      = {1'b0, pc_q[15:1]} < MemWordsW;
  assign entry         = '{instr: i_imem_instr, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (i_redirect) begin
      flush   = 1'b1;
      pc_d    = i_redirect_pc & 16'hFFFE;
      state_d = i_halt ? StHalt : StRun;
    end else if (state_q == StFault) begin
      state_d = StFault;
    end else if (i_halt) begin
      state_d = StHalt;
    end else if (!in_range) begin
      state_d = StFault;
    end else begin
      // Halt released: fetch resumes on this same edge.
      state_d = StRun;
      if (can_push) begin
        push = 1'b1;
        pc_d = pc_q + Z16_PC_STEP;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC & 16'hFFFE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  z16_fetch_queue #(
    .Depth(QUEUE_DEPTH)
  ) u_queue (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .flush_i(flush),
    .push_i (push),
    .entry_i(entry),
    .pop_i  (pop),
    .head_o (head),
    .count_o(q_count)
  );

  assign o_imem_addr = pc_q;
  assign o_instr     = head.instr;
  assign o_instr_pc  = head.pc;
  assign o_fault     = (state_q == StFault);

endmodule

// File: tb/tb_z16_instr_fetch_ctrl.sv
// Directed bench for z16_instr_fetch_ctrl with a 5-word combinational memory.
module tb_z16_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr, imem_instr, instr, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect, halt, fault;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [5];
  initial begin
    mem[0] = 16'h0040;
    mem[1] = 16'h605D;
    mem[2] = 16'h0000;
    mem[3] = 16'h0000;
    mem[4] = 16'h006C;
  end

  always_comb begin
    imem_instr = 16'hDEAD;
    if (imem_addr[15:1] < 15'd5) imem_instr = mem[imem_addr[3:1]];
  end

  always #5 clk = ~clk;

  z16_instr_fetch_ctrl #(
    .RESET_PC   (16'h0000),
    .QUEUE_DEPTH(2),
    .MEM_WORDS  (5)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_addr  (imem_addr),
    .i_imem_instr (imem_instr),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_halt       (halt),
    .o_fault      (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [15:0] ei, input logic [15:0] ep);
    check({tag, ".valid"}, {15'd0, instr_valid}, 16'd1);
    check({tag, ".instr"}, instr, ei);
    check({tag, ".pc"}, instr_pc, ep);
  endtask

  task automatic check_empty(input string tag, input logic [15:0] ea, input logic ef);
    check({tag, ".valid"}, {15'd0, instr_valid}, 16'd0);
    check({tag, ".instr"}, instr, 16'h0000);
    check({tag, ".addr"}, imem_addr, ea);
    check({tag, ".fault"}, {15'd0, fault}, {15'd0, ef});
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    step(); step();
    check_empty("reset", 16'h0000, 1'b0);
    check("reset.pc", instr_pc, 16'h0000);

    // Streaming with ready high until the range fault.
    rst = 1'b0;
    step(); check_head("s0", 16'h0040, 16'h0000);
    step(); check_head("s1", 16'h605D, 16'h0002);
    step(); check_head("s2", 16'h0000, 16'h0004);
    step(); check_head("s3", 16'h0000, 16'h0006);
    step(); check_head("s4", 16'h006C, 16'h0008);
    step(); check_empty("sfault", 16'h000A, 1'b1);

    // Backpressure from reset: queue fills, PC stalls.
    rst = 1'b1; instr_ready = 1'b0;
    step();
    rst = 1'b0;
    step(); step(); step();
    check_head("full", 16'h0040, 16'h0000);
    check("full.addr", imem_addr, 16'h0004);
    instr_ready = 1'b1;
    step(); check_head("bp1", 16'h605D, 16'h0002);
    step(); check_head("bp2", 16'h0000, 16'h0004);

    // Redirect to odd address: bit 0 dropped, word 6 is out of range.
    redirect = 1'b1; redirect_pc = 16'h000D;
    step(); check_empty("redir", 16'h000C, 1'b0);
    redirect = 1'b0;
    step(); check_empty("rfault", 16'h000C, 1'b1);
    step(); check_empty("rfault_hold", 16'h000C, 1'b1);

    // Redirect out of FAULT.
    redirect = 1'b1; redirect_pc = 16'h0002;
    step(); check_empty("unfault", 16'h0002, 1'b0);
    redirect = 1'b0;
    step(); check_head("resume", 16'h605D, 16'h0002);

    // Halt drains the queue without fetching.
    instr_ready = 1'b0;
    step(); check_head("pre_halt", 16'h605D, 16'h0002);
    check("pre_halt.addr", imem_addr, 16'h0006);
    halt = 1'b1; instr_ready = 1'b1;
    step(); check_head("halt1", 16'h0000, 16'h0004);
    check("halt1.addr", imem_addr, 16'h0006);
    step(); check_empty("halt2", 16'h0006, 1'b0);
    step(); check_empty("halt3", 16'h0006, 1'b0);
    halt = 1'b0;
    step(); check_head("unhalt", 16'h0000, 16'h0006);
    check("unhalt.addr", imem_addr, 16'h0008);

    // Reset wins over a simultaneous redirect while the queue is full and stalled.
    redirect = 1'b1; redirect_pc = 16'h0000; instr_ready = 1'b0;
    step();
    redirect = 1'b0;
    step(); step(); step();
    check_head("full2", 16'h0040, 16'h0000);
    check("full2.addr", imem_addr, 16'h0004);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0008; instr_ready = 1'b1;
    step(); check_empty("rst_prio", 16'h0000, 1'b0);
    rst = 1'b0; redirect = 1'b0;
    step(); check_head("post_rst", 16'h0040, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
